// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage.
// Memory models use IMEM_BASE as the instruction window base.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] IMEM_BASE = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        fault;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with bubble, hold and load controls.
// Bubble beats hold, hold beats load.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bubble,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] ld_pc,
  input  logic [31:0] ld_inst,
  input  logic        ld_fault,
  output logic [31:0] q_pc,
  output logic [31:0] q_inst,
  output logic        q_valid,
  output logic        q_fault
);

  if_id_t ent_d, ent_q;
  if_id_t bub;

  assign bub = '{pc: 32'h0, inst: BUBBLE_INST,
                 valid: 1'b0, fault: 1'b0};

  always_comb begin
    ent_d = ent_q;
    unique case (1'b1)
      bubble: ent_d = bub;
      hold:   ent_d = ent_q;
      load: begin
        ent_d.pc    = ld_pc;
        ent_d.inst  = ld_inst;
        ent_d.valid = 1'b1;
        ent_d.fault = ld_fault;
      end
      default: ent_d = ent_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) ent_q <= bub;
    else        ent_q <= ent_d;
  end

  assign q_pc    = ent_q.pc;
  assign q_inst  = ent_q.inst;
  assign q_valid = ent_q.valid;
  assign q_fault = ent_q.fault;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, redirect/stall/flush, fault detect, IF/ID.
// FETCH_PERF_EN adds fetch and stall-cycle counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0100_0000,
  parameter logic [31:0] IMEM_BYTES = 32'h0010_0000,
  parameter logic [31:0] NOP_INST   = fetch_pkg::NOP_INST
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic        imem_read_write,
  output logic [31:0] imem_data_out,
  input  logic [31:0] imem_data_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        if_id_fault,
  output logic [31:0] pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
`endif
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic         bubble, hold, load;
  logic [31:0]  ld_inst;
  logic         ld_fault;
  logic         bad_pc;

  // 33-bit compare keeps the upper bound from wrapping.
  logic [32:0] pc_ext, lo_ext, hi_ext;
  assign pc_ext = {1'b0, pc_q};
  assign lo_ext = {1'b0, RESET_PC};
  assign hi_ext = {1'b0, RESET_PC}
                + {1'b0, IMEM_BYTES} - 33'd4;
  assign bad_pc = (pc_q[1:0] != 2'b00)
               || (pc_ext < lo_ext)
               || (pc_ext > hi_ext);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bubble   = 1'b0;
    hold     = 1'b0;
    load     = 1'b0;
    ld_inst  = imem_data_in;
    ld_fault = 1'b0;
    unique case (state_q)
      BOOT: begin
        bubble  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d   = redirect_pc;
          bubble = 1'b1;
        end else if (flush) begin
          bubble = 1'b1;
          if (!stall) pc_d = pc_q + 32'd4;
        end else if (stall) begin
          hold = 1'b1;
        end else if (bad_pc) begin
          load     = 1'b1;
          ld_inst  = NOP_INST;
          ld_fault = 1'b1;
          state_d  = FAULT;
        end else begin
          load = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      FAULT: begin
        bubble = 1'b1;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end
      end
      default: begin
        bubble  = 1'b1;
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(.BUBBLE_INST(NOP_INST)) u_if_id (
    .clock    (clock),
    .reset    (reset),
    .bubble   (bubble),
    .hold     (hold),
    .load     (load),
    .ld_pc    (pc_q),
    .ld_inst  (ld_inst),
    .ld_fault (ld_fault),
    .q_pc     (if_id_pc),
    .q_inst   (if_id_inst),
    .q_valid  (if_id_valid),
    .q_fault  (if_id_fault)
  );

  assign pc              = pc_q;
  assign imem_address    = pc_q;
  assign imem_read_write = 1'b0;
  assign imem_data_out   = 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_d, fetched_q;
  logic [31:0] stalls_d, stalls_q;

  always_comb begin
    fetched_d = fetched_q;
    stalls_d  = stalls_q;
    if (load && !ld_fault && fetched_q != '1)
      fetched_d = fetched_q + 32'd1;
    if (state_q == RUN && stall
        && !redirect_valid && stalls_q != '1)
      stalls_d = stalls_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
    end
  end

  assign perf_fetched      = fetched_q;
  assign perf_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plus random.
// Reference model tracks pc and IF/ID at transaction level.
module tb_fetch_stage;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] BYTES = 32'h0010_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_out;
  logic [31:0] imem_data_in;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        if_id_fault;
  logic [31:0] pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == BASE)            return 32'h00A0_0093;
    if (a == BASE + 32'd4)    return 32'h0010_0113;
    return {a[15:0] ^ 16'hA5A5, a[31:16] + 16'h1234};
  endfunction

  assign imem_data_in = mem_word(imem_address);

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .imem_address    (imem_address),
    .imem_read_write (imem_read_write),
    .imem_data_out   (imem_data_out),
    .imem_data_in    (imem_data_in),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_id_pc        (if_id_pc),
    .if_id_inst      (if_id_inst),
    .if_id_valid     (if_id_valid),
    .if_id_fault     (if_id_fault),
    .pc              (pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0=boot 1=run 2=faulted.
  int          m_mode = 0;
  logic [31:0] m_pc   = BASE;
  logic [31:0] m_ipc  = 0;
  logic [31:0] m_inst = NOP;
  logic        m_v    = 0;
  logic        m_f    = 0;
  longint      m_fetched = 0;
  longint      m_stalls  = 0;

  function automatic bit out_of_window(input logic [31:0] a);
    longint x = longint'(a);
    return (x % 4 != 0) || (x < longint'(BASE))
        || (x > longint'(BASE) + longint'(BYTES) - 4);
  endfunction

  task automatic bubble_m();
    m_ipc = 0; m_inst = NOP; m_v = 0; m_f = 0;
  endtask

  task automatic model_step();
    if (!reset) begin
      m_mode = 0; m_pc = BASE; bubble_m();
      m_fetched = 0; m_stalls = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; bubble_m();
    end else if (m_mode == 2) begin
      bubble_m();
      if (redirect_valid) begin
        m_pc = redirect_pc; m_mode = 1;
      end
    end else begin
      if (stall && !redirect_valid) m_stalls++;
      if (redirect_valid) begin
        m_pc = redirect_pc; bubble_m();
      end else if (flush) begin
        bubble_m();
        if (!stall) m_pc = m_pc + 32'd4;
      end else if (stall) begin
      end else if (out_of_window(m_pc)) begin
        m_ipc = m_pc; m_inst = NOP;
        m_v = 1; m_f = 1; m_mode = 2;
      end else begin
        m_ipc = m_pc; m_inst = mem_word(m_pc);
        m_v = 1; m_f = 0; m_fetched++;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    chk("pc", pc, m_pc);
    chk("imem_address", imem_address, m_pc);
    chk("imem_rw", {31'b0, imem_read_write}, 32'h0);
    chk("imem_dout", imem_data_out, 32'h0);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_inst", if_id_inst, m_inst);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
    chk("if_id_fault", {31'b0, if_id_fault}, {31'b0, m_f});
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_stalls", perf_stall_cycles, 32'(m_stalls));
`endif
  endtask

  task automatic cyc(input logic st, input logic fl,
                     input logic rv, input logic [31:0] rp,
                     input logic rs);
    @(negedge clock);
    stall = st; flush = fl;
    redirect_valid = rv; redirect_pc = rp; reset = rs;
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run1();
    cyc(0, 0, 0, 32'h0, 1);
  endtask

  task automatic redir(input logic [31:0] t);
    cyc(0, 0, 1, t, 1);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_pc", pc, BASE);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_inst", if_id_inst, NOP);

    run1();
    chk("boot_pc", pc, BASE);
    chk("boot_valid", {31'b0, if_id_valid}, 32'h0);
    run1();
    chk("first_pc", if_id_pc, 32'h0100_0000);
    chk("first_inst", if_id_inst, 32'h00A0_0093);
    run1();
    chk("second_pc", if_id_pc, 32'h0100_0004);
    chk("second_inst", if_id_inst, 32'h0010_0113);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 1);
      chk("stall_pc", pc, 32'h0100_0008);
      chk("stall_ifid", if_id_pc, 32'h0100_0004);
    end
    run1();
    chk("resume_pc", if_id_pc, 32'h0100_0008);

    cyc(1, 0, 1, 32'h0100_0040, 1);
    chk("redir_pc", pc, 32'h0100_0040);
    chk("redir_valid", {31'b0, if_id_valid}, 32'h0);
    run1();
    chk("redir_cap", if_id_pc, 32'h0100_0040);

    redir(32'h0100_0010);
    cyc(0, 1, 0, 0, 1);
    chk("flush_valid", {31'b0, if_id_valid}, 32'h0);
    chk("flush_inst", if_id_inst, NOP);
    chk("flush_pc", pc, 32'h0100_0014);
    cyc(1, 1, 0, 0, 1);
    chk("flush_stall_pc", pc, 32'h0100_0014);

    redir(32'h0100_0042);
    run1();
    chk("mis_fault", {31'b0, if_id_fault}, 32'h1);
    chk("mis_inst", if_id_inst, NOP);
    run1();
    chk("mis_frozen", pc, 32'h0100_0042);
    redir(32'h0100_0000);
    run1();
    chk("resume_inst", if_id_inst, 32'h00A0_0093);

    redir(32'h010F_FFFC);
    run1();
    chk("last_ok", {31'b0, if_id_fault}, 32'h0);
    run1();
    chk("past_end", {31'b0, if_id_fault}, 32'h1);

    redir(32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 1);
    chk("wrap_pc", pc, 32'h0);
    run1();
    chk("wrap_fault", {31'b0, if_id_fault}, 32'h1);

    redir(32'h0110_0000);
    run1();
    chk("oob_fault", {31'b0, if_id_fault}, 32'h1);
    cyc(0, 0, 0, 0, 0);
    chk("fault_rst_pc", pc, BASE);
    run1();
    chk("fault_rst_boot", {31'b0, if_id_valid}, 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic st, fl, rv, rs;
      logic [31:0] rp;
      int k;
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 79) != 0);
      k  = $urandom_range(0, 9);
      if (k == 0)
        rp = BASE + 32'($urandom_range(0, 63) * 4) + 32'd2;
      else if (k == 1)
        rp = BASE + BYTES - 32'd4 * 32'($urandom_range(0, 2));
      else if (k == 2)
        rp = $urandom();
      else
        rp = BASE + 32'($urandom_range(0, 255) * 4);
      cyc(st, fl, rv, rp, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the five-stage RISC-V pipeline.
- Owns the PC and drives the instruction memory's address and read/write controls. Captures the instruction returned combinationally in the same cycle and registers it with its PC into the IF/ID pipeline register for decode.
- Handles stall, flush and branch/jump redirect from downstream stages.
- Detects misaligned and out-of-range fetches.

Parameters:
- RESET_PC, 32'h01000000, PC loaded on reset; base of instruction memory.
- IMEM_BYTES, 32'h00100000, size of the instruction memory window in bytes.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_address  out  32  byte address to instruction memory; equals pc.
- imem_read_write  out  1  constant 0; this stage never writes.
- imem_data_out  out  32  constant 0.
- imem_data_in  in  32  instruction word returned combinationally for imem_address.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  replace IF/ID contents with a bubble.
- redirect_valid  in  1  load redirect_pc into PC.
- redirect_pc  in  32  branch/jump target from execute.
- if_id_pc  out  32  PC of the registered instruction.
- if_id_inst  out  32  registered instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_fault  out  1  registered entry is a fetch fault; if_id_inst = NOP_INST.
- pc  out  32  current fetch PC.

Behaviour:
- Reset (reset==0 at edge):
  - pc=RESET_PC; if_id_pc=0; if_id_inst=NOP_INST; if_id_valid=0; if_id_fault=0; state=BOOT.
  - Reset asserted mid-operation discards all in-flight state the same edge.
- FSM states:
  - BOOT: one cycle after reset release. pc is held and IF/ID stays invalid, so memory settles before the first capture. BOOT->RUN unconditionally.
  - RUN: normal fetch.
  - FAULT: entered when a faulting fetch is captured. pc is frozen and IF/ID captures bubbles (valid=0). The only exit is redirect_valid, which goes to RUN with pc=redirect_pc.
- Fault condition (combinational on pc): pc[1:0]!=0, or pc<RESET_PC, or pc>RESET_PC+IMEM_BYTES-4. Compare in 33 bits so the upper bound does not overflow.
- RUN, per edge, highest priority first:
  - redirect_valid: pc<=redirect_pc; IF/ID<=bubble (valid=0, inst=NOP_INST, fault=0). Overrides stall and flush.
  - flush without redirect: IF/ID<=bubble; pc<=pc+4 unless stall.
  - stall: pc and IF/ID hold.
  - Otherwise, fault condition true: IF/ID<={pc, NOP_INST, valid=1, fault=1}; pc holds; state<=FAULT.
  - Otherwise: IF/ID<={pc, imem_data_in, valid=1, fault=0}; pc<=pc+4.
- PC arithmetic is modulo 2^32. A wrap at 32'hFFFFFFFC yields 0, which then faults as out of range.
- Latency: an instruction at pc appears on if_id_* one edge after pc is presented. Redirect gives a 1-cycle bubble.
- Flush and stall together: bubble inserted, pc holds.
- Redirect to a misaligned target: accepted; faults on the next RUN fetch.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched (32) and perf_stall_cycles (32).
  - perf_fetched increments on every capture with valid=1, fault=0.
  - perf_stall_cycles increments on every RUN cycle with stall=1 and no redirect.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - fetch state encoding (BOOT=2'd0, RUN=2'd1, FAULT=2'd2);
  - NOP_INST constant;
  - default IMEM base 32'h01000000, shared with the memory model.
- Sub-module if_id_reg holds the IF/ID register: hold/bubble/load controls with the bubble reset values above.

Test Plan:
- Reset release, memory preloaded with words 0x00A00093,0x00100113 -> cycle 1 BOOT, valid=0. Then if_id={0x01000000,0x00A00093}, next {0x01000004,0x00100113}.
- stall=1 for 3 cycles at pc=0x01000008 -> pc and if_id unchanged for 3 edges; fetch resumes at 0x01000008 with no loss or duplicate.
- redirect_valid=1, redirect_pc=0x01000040, with stall=1 in the same cycle -> next edge pc=0x01000040, valid=0. The following edge captures the inst at 0x01000040.
- flush=1 alone at pc=0x01000010 -> if_id_valid=0, if_id_inst=0x00000013, pc=0x01000014.
- redirect_pc=0x01000042 -> captured fault=1, inst=NOP, state FAULT, pc frozen. A later redirect to 0x01000000 resumes normal fetch.
- redirect_pc=0x01100000 (one past the window) -> fault=1. Also assert reset while in FAULT -> pc=0x01000000, state BOOT.
